// File: rtl/dec_sel_pkg.sv
// Shared definitions for the dec3x8 select sequencer: state encoding,
// terminal select codes and the code-stepping helpers.
package dec_sel_pkg;

    localparam int DWELL_W_DEF = 4;

    localparam logic [2:0] CODE_MAX = 3'b111;
    localparam logic [2:0] CODE_MIN = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // dir = 0 counts up, dir = 1 counts down; 3-bit arithmetic gives the wrap.
    function automatic logic [2:0] step_code(input logic [2:0] code, input logic dir);
        return dir ? code - 3'd1 : code + 3'd1;
    endfunction

    function automatic logic [2:0] terminal_code(input logic dir);
        return dir ? CODE_MIN : CODE_MAX;
    endfunction

endpackage

// File: rtl/dwell_cnt.sv
// Dwell counter: loads a hold count, decrements toward zero, flags zero.
module dwell_cnt #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dec_sel_seq.sv
// Select-code sequencer for a dec3x8: steps {X,Y,Z} up or down, holding each
// code for Dwell+1 cycles, either looping or making a single pass.
module dec_sel_seq
    import dec_sel_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Step,
    input  logic               Dir,
    input  logic               Loop,
    input  logic [DWELL_W-1:0] Dwell,
    output logic               X,
    output logic               Y,
    output logic               Z,
    output logic               Busy,
    output logic               Done,
    output state_t             dbg_state
);

    state_t     state;
    logic [2:0] code;

    logic cnt_zero;
    logic cnt_load;
    logic cnt_dec;
    logic run_go;
    logic run_finish;
    logic run_adv;

    // Stop suppresses every RUN action; a single pass ends at the terminal
    // code instead of wrapping.
    always_comb begin
        run_go     = (state == RUN) && !Stop;
        run_finish = run_go && cnt_zero && !Loop && (code == terminal_code(Dir));
        run_adv    = run_go && cnt_zero && !run_finish;
        cnt_load   = ((state == IDLE) && Start && !Stop) || run_adv;
        cnt_dec    = run_go && !cnt_zero;
    end

    dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (Clk),
        .rst      (Rst),
        .load     (cnt_load),
        .load_val (Dwell),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Busy and Done are registered from the next state so they line up
    // with the state register itself.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            code  <= CODE_MIN;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Busy <= 1'b0;
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Stop) begin
                        state <= RUN;
                        Busy  <= 1'b1;
                    end else if (Step && !Start) begin
                        code <= step_code(code, Dir);
                    end
                end
                RUN: begin
                    if (Stop) begin
                        state <= IDLE;
                    end else if (run_finish) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else begin
                        Busy <= 1'b1;
                        if (run_adv) begin
                            code <= step_code(code, Dir);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {X, Y, Z} = code;
    assign dbg_state = state;

endmodule

// File: tb/tb_dec_sel_seq.sv
// Directed bench for dec_sel_seq: hand-computed code/state sequences,
// with the select outputs fed through a dec3x8 model and checked each cycle.
module tb_dec_sel_seq;

    localparam int DWELL_W = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               step;
    logic               dir;
    logic               loop;
    logic [DWELL_W-1:0] dwell;
    logic               x, y, z;
    logic               busy;
    logic               done;
    logic [1:0]         dbg_state;
    logic [7:0]         dn;

    int n_vec  = 0;
    int n_miss = 0;

    logic [2:0] exp_q[$];

    dec_sel_seq #(
        .DWELL_W (DWELL_W)
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .Start     (start),
        .Stop      (stop),
        .Step      (step),
        .Dir       (dir),
        .Loop      (loop),
        .Dwell     (dwell),
        .X         (x),
        .Y         (y),
        .Z         (z),
        .Busy      (busy),
        .Done      (done),
        .dbg_state (dbg_state)
    );

    // Downstream dec3x8
    always_comb begin
        dn = 8'b0;
        dn[{x, y, z}] = 1'b1;
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [2:0] code, input logic [1:0] st);
        logic [7:0] oh;
        oh = 8'd1 << code;
        check({tag, ".xyz"},   {5'b0, x, y, z},     {5'b0, code});
        check({tag, ".state"}, {6'b0, dbg_state},   {6'b0, st});
        check({tag, ".busy"},  {7'b0, busy},        {7'b0, (st == S_RUN)});
        check({tag, ".done"},  {7'b0, done},        {7'b0, (st == S_DONE)});
        check({tag, ".dec"},   dn,                  oh);
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; step = 0; dir = 0; loop = 0; dwell = '0;

        // Reset held two cycles
        tick(); tick();
        expect_cycle("reset", 3'b000, S_IDLE);
        rst = 1'b0;

        // Single pass up, Dwell=0
        dwell = 4'd0; dir = 0; loop = 0;
        start = 1; tick(); start = 0;
        expect_cycle("up_start", 3'b000, S_RUN);
        for (int c = 1; c <= 7; c++) begin
            tick();
            expect_cycle("up_run", 3'(c), S_RUN);
        end
        tick();
        expect_cycle("up_done", 3'b111, S_DONE);
        tick();
        expect_cycle("up_idle", 3'b111, S_IDLE);

        // Manual step wraps 111 -> 000
        step = 1; tick(); step = 0;
        expect_cycle("step_wrap_up", 3'b000, S_IDLE);

        // Looping down, Dwell=2, Step pulses ignored, Stop at 101
        dwell = 4'd2; dir = 1; loop = 1;
        for (int k = 0; k < 3; k++) exp_q.push_back(3'b000);
        for (int c = 7; c >= 0; c--)
            for (int k = 0; k < 3; k++) exp_q.push_back(3'(c));
        for (int k = 0; k < 3; k++) exp_q.push_back(3'b111);
        for (int k = 0; k < 3; k++) exp_q.push_back(3'b110);
        exp_q.push_back(3'b101);
        start = 1; tick(); start = 0;
        expect_cycle("loop_start", exp_q.pop_front(), S_RUN);
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i == 4 || i == 10) step = 1;
            tick();
            step = 0;
            expect_cycle("loop_run", exp_q.pop_front(), S_RUN);
        end
        stop = 1; tick(); stop = 0;
        expect_cycle("loop_stop", 3'b101, S_IDLE);
        tick();
        expect_cycle("loop_stop_hold", 3'b101, S_IDLE);

        // Start and Stop together in IDLE
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        expect_cycle("start_stop", 3'b101, S_IDLE);

        // Reset mid-RUN at 101
        dwell = 4'd5;
        start = 1; tick(); start = 0;
        expect_cycle("rst_run0", 3'b101, S_RUN);
        tick();
        expect_cycle("rst_run1", 3'b101, S_RUN);
        rst = 1; tick(); rst = 0;
        expect_cycle("rst_mid_run", 3'b000, S_IDLE);

        // Step down wraps 000 -> 111; Start beats Step
        dir = 1;
        step = 1; tick(); step = 0;
        expect_cycle("step_wrap_dn", 3'b111, S_IDLE);
        start = 1; step = 1; tick(); start = 0; step = 0;
        expect_cycle("start_over_step", 3'b111, S_RUN);
        stop = 1; tick(); stop = 0;
        expect_cycle("stop_run", 3'b111, S_IDLE);

        // Single pass down ending at 000; inputs ignored in DONE
        dir = 0;
        step = 1; tick(); tick(); step = 0;
        expect_cycle("step_to_001", 3'b001, S_IDLE);
        dir = 1; loop = 0; dwell = 4'd0;
        start = 1; tick(); start = 0;
        expect_cycle("dn_start", 3'b001, S_RUN);
        tick();
        expect_cycle("dn_run", 3'b000, S_RUN);
        tick();
        expect_cycle("dn_done", 3'b000, S_DONE);
        start = 1; step = 1; stop = 1; tick(); start = 0; step = 0; stop = 0;
        expect_cycle("done_ignores", 3'b000, S_IDLE);
        tick();
        expect_cycle("dn_idle", 3'b000, S_IDLE);

        // Dir change mid-RUN applies at the next advance
        dir = 0; loop = 1; dwell = 4'd1;
        start = 1; tick(); start = 0;
        expect_cycle("dir_start", 3'b000, S_RUN);
        tick();
        expect_cycle("dir_hold", 3'b000, S_RUN);
        dir = 1; tick();
        expect_cycle("dir_change", 3'b111, S_RUN);
        stop = 1; tick(); stop = 0;
        expect_cycle("dir_stop", 3'b111, S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dec_sel_seq.md
DEC_SEL_SEQ -- requirements
Module: dec_sel_seq

Interface
REQ-001 Parameter DWELL_W, default 4, width of the dwell count.
REQ-002 Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 Start  input  1  begin sequencing (honoured in IDLE only).
REQ-005 Stop  input  1  abort sequencing and return to IDLE.
REQ-006 Step  input  1  manual single advance (honoured in IDLE only).
REQ-007 Dir  input  1  0 = count up, 1 = count down.
REQ-008 Loop  input  1  1 = wrap continuously, 0 = single pass.
REQ-009 Dwell  input  DWELL_W  extra cycles each code is held in RUN.
REQ-010 X, Y, Z  output  1 each  3-bit select code for the downstream dec3x8; X is MSB, Z is LSB.
REQ-011 Busy  output  1  high while in RUN.
REQ-012 Done  output  1  one-cycle pulse at the end of a single pass.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-014 IDLE, Start=1, Stop=0: next state RUN; dwell counter loads Dwell; code unchanged.
REQ-015 IDLE, Start=1 and Stop=1 together: Stop wins; stay in IDLE.
REQ-016 IDLE, Step=1, Start=0: code advances by one per Dir, wrapping 111->000 up and 000->111 down; state stays IDLE.
REQ-017 IDLE, Start=1 and Step=1 together: Start wins; Step is ignored.
REQ-018 RUN, Stop=1: next state IDLE; code holds; Stop has priority over any advance in the same cycle.
REQ-019 RUN, counter non-zero: counter decrements by 1; code holds.
REQ-020 RUN, counter zero, advance permitted: code advances per Dir and counter reloads from Dwell (Dwell is resampled at every reload); each code is therefore held Dwell+1 cycles, and Dwell=0 advances every cycle.
REQ-021 RUN, Loop=1: code wraps at the terminal value (111 up, 000 down) and RUN continues indefinitely; Done never asserts.
REQ-022 RUN, Loop=0, counter zero at the terminal code for the current Dir: no advance; next state DONE; code holds at the terminal value.
REQ-023 DONE: Done=1 for exactly one cycle, Busy=0, then unconditionally IDLE; Start, Step and Stop are ignored in DONE.
REQ-024 Start and Step SHALL be ignored in RUN.
REQ-025 Busy SHALL be a registered decode of state==RUN; Done SHALL be a registered decode of state==DONE.
REQ-026 A Dir change mid-RUN SHALL take effect at the next advance.

Reset
REQ-027 Rst=1 SHALL force, on the next rising edge: state IDLE; X=Y=Z=0; counter 0; Busy=0; Done=0.
REQ-028 Rst SHALL override every other input in every state, including mid-RUN and DONE.

Structure
REQ-029 Shared package dec_sel_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), the DWELL_W default, and the terminal codes CODE_MAX=3'b111 and CODE_MIN=3'b000.
REQ-030 The dwell counter (load, decrement, zero flag) SHALL be one sub-module, dwell_cnt; the FSM and code register SHALL stay in dec_sel_seq.
REQ-031 The block SHALL be synthesisable with no latches and no combinational path from inputs to outputs.

Verification
REQ-032 Rst held high 2 cycles -> XYZ=000, Busy=0, Done=0, state IDLE.
REQ-033 Dwell=0, Dir=0, Loop=0, Start pulse from 000 -> XYZ steps 001..111 on consecutive cycles, then Done=1 for 1 cycle, Busy=0, XYZ holds 111.
REQ-034 Dwell=2, Dir=1, Loop=1, start at 000 -> each code held 3 cycles: 111, 110, ..., 000, then wraps to 111; Stop at 101 -> IDLE next cycle, XYZ=101 held, Busy=0, Done=0.
REQ-035 IDLE, XYZ=111, Dir=0, Step pulse -> XYZ=000; Step pulse during RUN -> no extra advance.
REQ-036 Start and Stop asserted together in IDLE -> stays IDLE, Busy=0; Rst asserted mid-RUN at 101 -> XYZ=000, IDLE on the next cycle.
REQ-037 Bench SHALL drive the outputs into dec3x8 and check exactly one Dn is high, matching {X,Y,Z}, every cycle.
